// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential binary-to-packed-BCD converter (double dabble).
// Captures bin on a rising edge of init_in, then processes one bit per
// clock. It pulses done for one cycle when bcd takes the new result.
module bin2bcd_seq #(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 5
) (
    input  logic                  clk,
    input  logic                  rst,      // asynchronous, active low
    input  logic                  init_in,
    input  logic [WIDTH-1:0]      bin,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  busy,
    output logic                  done
);

    localparam int BW = 4 * DIGITS;        // BCD field width
    localparam int SW = BW + WIDTH;        // full shift register width
    localparam int CW = $clog2(WIDTH + 1); // bit counter width

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [SW-1:0]   shift_q, shift_d;
    logic [CW-1:0]   count_q, count_d;
    logic [BW-1:0]   bcd_q, bcd_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            init_dly_q, init_dly_d;

    // The shift register after the add-3 step. The shift happens in the FSM.
    logic [SW-1:0]   adjusted;

    assign adjusted[WIDTH-1:0] = shift_q[WIDTH-1:0];

    // Apply add-3 to each BCD nibble that is >= 5, so the following shift
    // carries correctly into the next decimal digit.
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_adj
        logic [3:0] nib;
        assign nib = shift_q[WIDTH + 4*gi +: 4];
        assign adjusted[WIDTH + 4*gi +: 4] = (nib >= 4'd5) ? nib + 4'd3 : nib;
    end

    // Next-state logic. A start is a 0->1 edge of init_in against its delayed
    // copy, and it is accepted only in IDLE. Edges seen in other states are
    // dropped.
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        count_d    = count_q;
        bcd_d      = bcd_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        init_dly_d = init_in;

        case (state_q)
            S_IDLE: begin
                if (init_in && !init_dly_q) begin
                    shift_d = {{BW{1'b0}}, bin};
                    count_d = CW'(WIDTH);
                    busy_d  = 1'b1;
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                shift_d = adjusted << 1;
                count_d = count_q - 1'b1;
                if (count_q == CW'(1)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                bcd_d   = shift_q[SW-1:WIDTH];
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // FSM and datapath registers. Reset at any time aborts a conversion and
    // clears the result.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            shift_q    <= '0;
            count_q    <= '0;
            bcd_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            init_dly_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            count_q    <= count_d;
            bcd_q      <= bcd_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            init_dly_q <= init_dly_d;
        end
    end

    assign bcd  = bcd_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Testbench for bin2bcd_seq. Expected results are queued when a start is
// driven, and they are popped and checked when done pulses.
`timescale 1ns/1ps
module tb_bin2bcd_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        init_in = 1'b0;
    logic [15:0] bin = '0;
    logic [19:0] bcd;
    logic        busy;
    logic        done;

    bin2bcd_seq #(.WIDTH(16), .DIGITS(5)) dut (
        .clk     (clk),
        .rst     (rst),
        .init_in (init_in),
        .bin     (bin),
        .bcd     (bcd),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [19:0] bcd;
        int          due;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    int   done_cnt = 0;
    int   d0;
    logic prev_done = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [19:0] to_bcd(input int v);
        logic [19:0] r;
        int x;
        x = v;
        r = '0;
        for (int d = 0; d < 5; d++) begin
            r[4*d +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    // Cycle counter: counts rising edges.
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Output monitor: sample on the falling edge and check each done pulse.
    initial forever begin
        @(negedge clk);
        if (done === 1'b1) begin
            done_cnt++;
            if (prev_done === 1'b1) chk("done_width", 1, 0);
            if (sb.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                e = sb.pop_front();
                chk("bcd", bcd, e.bcd);
                chk("latency", cyc, e.due);
                chk("busy_at_done", busy, 0);
                $display("[TB] done bcd=%05h exp=%05h cycle=%0d", bcd, e.bcd, cyc);
            end
        end
        prev_done = done;
    end

    // Drive a one-cycle start pulse. If it should be accepted, queue the result
    // expected 18 rising edges later: the sampling edge plus 17 more.
    task automatic start(input logic [15:0] v, input bit expect_it);
        @(negedge clk);
        bin = v;
        init_in = 1'b1;
        if (expect_it) sb.push_back('{to_bcd(int'(v)), cyc + 18});
        $display("[TB] start bin=%0d expected=%0d", v, expect_it);
        @(negedge clk);
        init_in = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 60 && sb.size() > 0; i++) @(negedge clk);
        chk("drain_timeout", sb.size(), 0);
    endtask

    initial begin
        // 1. reset
        repeat (2) @(negedge clk);
        chk("rst_bcd", bcd, 20'h0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // 2. simple conversion, busy checked mid-way
        start(16'd20, 1'b1);
        repeat (5) @(negedge clk);
        chk("busy_mid", busy, 1);
        chk("done_mid", done, 0);
        drain();

        // 3. extremes, started back to back right after done
        start(16'd65535, 1'b1);
        drain();
        start(16'd0, 1'b1);
        drain();
        start(16'd9, 1'b1);
        drain();

        // 4. level held high: exactly one conversion
        d0 = done_cnt;
        @(negedge clk);
        bin = 16'd36;
        init_in = 1'b1;
        sb.push_back('{to_bcd(36), cyc + 18});
        repeat (40) @(negedge clk);
        init_in = 1'b0;
        repeat (20) @(negedge clk);
        chk("held_one_done", done_cnt - d0, 1);
        chk("held_bcd_hold", bcd, 20'h00036);

        // 5. start edge during SHIFT ignored, bin change ignored
        d0 = done_cnt;
        start(16'd2, 1'b1);
        repeat (4) @(negedge clk);
        bin = 16'd999;
        init_in = 1'b1;
        @(negedge clk);
        init_in = 1'b0;
        drain();
        repeat (25) @(negedge clk);
        chk("ignored_one_done", done_cnt - d0, 1);
        chk("ignored_bcd", bcd, 20'h00002);

        // 6. reset mid-conversion aborts it
        d0 = done_cnt;
        start(16'd12345, 1'b1);
        repeat (6) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("abort_bcd", bcd, 20'h0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        sb.delete();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (25) @(negedge clk);
        chk("abort_no_done", done_cnt - d0, 0);
        start(16'd12345, 1'b1);
        drain();
        chk("after_abort_done", done_cnt - d0, 1);

        // a few random values
        for (int i = 0; i < 6; i++) begin
            start(16'($urandom_range(0, 65535)), 1'b1);
            drain();
        end

        repeat (3) @(negedge clk);
        chk("sb_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
